// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle RV32I-subset datapath: decodes IR fields, sequences selects and write enables.
// Optional retired-instruction counter (and its CNT_W parameter and port) enabled by defining RETIRE_CNT_EN.
module multicycle_controller #(
  parameter int HALT_ON_ZERO = 1
`ifdef RETIRE_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OPCode,
  input  logic [2:0] Func3,
  input  logic [6:0] Func7,
  input  logic       Zero,
  input  logic       ALU_msb,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       halted,
  output logic       illegal
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_EXEC = 4'd11,
    S_LUI       = 4'd12,
    S_HALT      = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_ZERO   = 7'b0000000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLTU = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  state_t state_q, state_d;

  logic [2:0] alu_func;
  logic       func_ok;
  logic       br_taken;
  logic       br_ok;

  // Func3/Func7 decode shared by both execute states; Func7 only matters for R-type.
  always_comb begin
    alu_func = ALU_ADD;
    func_ok  = 1'b1;
    case (Func3)
      3'b000:  alu_func = (state_q == S_EXEC_R && Func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_func = ALU_AND;
      3'b110:  alu_func = ALU_OR;
      3'b010:  alu_func = ALU_SLT;
      3'b011:  alu_func = ALU_SLTU;
      3'b100:  alu_func = ALU_XOR;
      default: func_ok  = 1'b0;
    endcase
    if (state_q == S_EXEC_R && Func7 != 7'b0000000 &&
        !(Func7 == 7'b0100000 && Func3 == 3'b000)) begin
      func_ok = 1'b0;
    end
  end

  always_comb begin
    br_taken = 1'b0;
    br_ok    = 1'b1;
    case (Func3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100:  br_taken = ALU_msb;
      3'b101:  br_taken = ~ALU_msb;
      default: br_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        PCWrite   = mem_ready;
        IRWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        if (OPCode == OP_BRANCH)   ImmSrc = IMM_B;
        else if (OPCode == OP_JAL) ImmSrc = IMM_J;
        case (OPCode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_EXEC;
          OP_LUI:            state_d = S_LUI;
          OP_ZERO:           state_d = (HALT_ON_ZERO != 0) ? S_HALT : S_ILLEGAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        ImmSrc  = (OPCode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (OPCode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ResultSrc = 2'd1;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_WRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = (state_q == S_EXEC_I) ? 2'd1 : 2'd0;
        ALUControl = alu_func;
        state_d    = func_ok ? S_ALU_WB : S_ILLEGAL;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'd2;
        ALUControl = ALU_SUB;
        PCWrite    = br_ok & br_taken;
        state_d    = br_ok ? S_FETCH : S_ILLEGAL;
      end
      // Shared by jal and jalr: ALUOut holds the target, ALU forms OldPC+4 for the link.
      S_JAL: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        PCWrite = 1'b1;
        state_d = S_ALU_WB;
      end
      S_JALR_EXEC: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        state_d = S_JAL;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = 2'd3;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:    state_d = S_HALT;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Flags are decoded from the terminal states, so they are mutually exclusive and sticky until reset.
  assign halted  = (state_q == S_HALT);
  assign illegal = (state_q == S_ILLEGAL);

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retired_q <= '0;
    else      retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors against hand-derived expectations.
// Retired-counter checks are compiled in when RETIRE_CNT_EN is defined.
module tb_multicycle_controller;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd4;

  logic       clk;
  logic       rst;
  logic [6:0] OPCode;
  logic [2:0] Func3;
  logic [6:0] Func7;
  logic       Zero;
  logic       ALU_msb;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
`ifdef RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int n_run;
  int n_fail;

  logic [31:0] outs;
  assign outs = {13'd0, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrc, RegWrite, halted, illegal};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .OPCode(OPCode), .Func3(Func3), .Func7(Func7),
    .Zero(Zero), .ALU_msb(ALU_msb), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .halted(halted), .illegal(illegal)
`ifdef RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ov(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic rw, input logic h,
                                     input logic il);
    return {13'd0, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, h, il};
  endfunction

  function automatic logic [31:0] e_fetch(input logic rdy);
    return ov(rdy, 1'b0, 1'b0, rdy, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [31:0] e_dec(input logic [2:0] imm);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd0, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [31:0] e_exec(input logic i_type, input logic [2:0] alu);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, {1'b0, i_type}, alu, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [31:0] e_madr(input logic [2:0] imm);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [31:0] e_branch(input logic pcw);
    return ov(pcw, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [31:0] E_ALU_WB, E_MREAD, E_MWB, E_MWRITE, E_JAL, E_LUI, E_HALT, E_ILL;

  task automatic set_ir(input logic [31:0] ir);
    OPCode = ir[6:0];
    Func3  = ir[14:12];
    Func7  = ir[31:25];
  endtask

  // Inputs are set just after a rising edge; outputs are sampled 2 time units later.
  task automatic step(input string tag, input logic [31:0] exp);
    #2;
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk(tag, outs, e_fetch(1'b0));
`ifdef RETIRE_CNT_EN
    chk({tag, "_retired"}, retired, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input string tag, input logic [31:0] ir, input logic [2:0] alu);
    set_ir(ir);
    mem_ready = 1'b1;
    step({tag, "_fetch"}, e_fetch(1'b1));
    mem_ready = 1'b0;
    step({tag, "_dec"}, e_dec(IMM_I));
    step({tag, "_exec"}, e_exec(~ir[5], alu));
    step({tag, "_wb"}, E_ALU_WB);
  endtask

  task automatic run_lw(input string tag, input int stalls);
    set_ir(32'h00040483);
    mem_ready = 1'b1;
    step({tag, "_fetch"}, e_fetch(1'b1));
    step({tag, "_dec"}, e_dec(IMM_I));
    step({tag, "_madr"}, e_madr(IMM_I));
    mem_ready = 1'b0;
    repeat (stalls) step({tag, "_mread_stall"}, E_MREAD);
    mem_ready = 1'b1;
    step({tag, "_mread"}, E_MREAD);
    step({tag, "_mwb"}, E_MWB);
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ir, input logic [2:0] dimm,
                             input int mid);
    set_ir(ir);
    mem_ready = 1'b1;
    step({tag, "_fetch"}, e_fetch(1'b1));
    step({tag, "_dec"}, e_dec(dimm));
    for (int k = 0; k < mid; k++) begin
      #2;
      chk({tag, "_mid_no_write"}, {29'd0, PCWrite, MemWrite, RegWrite}, 32'd0);
      @(posedge clk);
      #1;
    end
    step({tag, "_ill0"}, E_ILL);
    mem_ready = 1'b0;
    step({tag, "_ill1"}, E_ILL);
    do_reset({tag, "_rst"});
  endtask

  logic [31:0] alu_ir  [12];
  logic [2:0]  alu_exp [12];
  logic [31:0] br_ir   [6];
  logic        br_z    [6];
  logic        br_m    [6];
  logic        br_pcw  [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_run = 0;
    n_fail = 0;
    E_ALU_WB = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    E_MREAD  = ov(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    E_MWB    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    E_MWRITE = ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    E_JAL    = ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    E_LUI    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    E_HALT   = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    E_ILL    = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);

    alu_ir[0]  = 32'h00000433; alu_exp[0]  = 3'd0;  // add
    alu_ir[1]  = 32'h40000433; alu_exp[1]  = 3'd1;  // sub
    alu_ir[2]  = 32'h00007433; alu_exp[2]  = 3'd2;  // and
    alu_ir[3]  = 32'h00006433; alu_exp[3]  = 3'd3;  // or
    alu_ir[4]  = 32'h00002433; alu_exp[4]  = 3'd4;  // slt
    alu_ir[5]  = 32'h00003433; alu_exp[5]  = 3'd5;  // sltu
    alu_ir[6]  = 32'h00004433; alu_exp[6]  = 3'd6;  // xor
    alu_ir[7]  = 32'h40000413; alu_exp[7]  = 3'd0;  // addi, imm bit 30 set must not select sub
    alu_ir[8]  = 32'h00002413; alu_exp[8]  = 3'd4;  // slti
    alu_ir[9]  = 32'h00003413; alu_exp[9]  = 3'd5;  // sltiu
    alu_ir[10] = 32'h00004413; alu_exp[10] = 3'd6;  // xori
    alu_ir[11] = 32'h00007413; alu_exp[11] = 3'd2;  // andi

    br_ir[0] = 32'h00000063; br_z[0] = 1'b1; br_m[0] = 1'b0; br_pcw[0] = 1'b1;  // beq taken
    br_ir[1] = 32'h00001063; br_z[1] = 1'b1; br_m[1] = 1'b0; br_pcw[1] = 1'b0;  // bne not taken
    br_ir[2] = 32'h00004063; br_z[2] = 1'b0; br_m[2] = 1'b1; br_pcw[2] = 1'b1;  // blt taken
    br_ir[3] = 32'h00005063; br_z[3] = 1'b0; br_m[3] = 1'b1; br_pcw[3] = 1'b0;  // bge not taken
    br_ir[4] = 32'h00001063; br_z[4] = 1'b0; br_m[4] = 1'b0; br_pcw[4] = 1'b1;  // bne taken
    br_ir[5] = 32'h00000063; br_z[5] = 1'b0; br_m[5] = 1'b1; br_pcw[5] = 1'b0;  // beq not taken

    rst = 1'b0;
    mem_ready = 1'b0;
    Zero = 1'b0;
    ALU_msb = 1'b0;
    set_ir(32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs, e_fetch(1'b0));
`ifdef RETIRE_CNT_EN
    chk("reset_retired", retired, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("fetch_wait", e_fetch(1'b0));

    for (int i = 0; i < 12; i++) run_alu($sformatf("alu%0d", i), alu_ir[i], alu_exp[i]);

    run_lw("lw", 3);

    set_ir(32'h00802023);
    mem_ready = 1'b1;
    step("sw_fetch", e_fetch(1'b1));
    step("sw_dec", e_dec(IMM_I));
    step("sw_madr", e_madr(IMM_S));
    mem_ready = 1'b0;
    step("sw_mwrite_stall", E_MWRITE);
    mem_ready = 1'b1;
    step("sw_mwrite", E_MWRITE);

    for (int i = 0; i < 6; i++) begin
      set_ir(br_ir[i]);
      mem_ready = 1'b1;
      Zero = br_z[i];
      ALU_msb = br_m[i];
      step($sformatf("br%0d_fetch", i), e_fetch(1'b1));
      step($sformatf("br%0d_dec", i), e_dec(IMM_B));
      step($sformatf("br%0d_branch", i), e_branch(br_pcw[i]));
    end
    Zero = 1'b0;
    ALU_msb = 1'b0;

    set_ir(32'hFE5FFFEF);
    step("jal_fetch", e_fetch(1'b1));
    step("jal_dec", e_dec(IMM_J));
    step("jal_jal", E_JAL);
    step("jal_wb", E_ALU_WB);

    set_ir(32'h00048067);
    step("jalr_fetch", e_fetch(1'b1));
    step("jalr_dec", e_dec(IMM_I));
    step("jalr_exec", e_madr(IMM_I));
    step("jalr_jal", E_JAL);
    step("jalr_wb", E_ALU_WB);

    set_ir(32'h000004B7);
    step("lui_fetch", e_fetch(1'b1));
    step("lui_dec", e_dec(IMM_I));
    step("lui_lui", E_LUI);

    set_ir(32'h00000000);
    step("halt_fetch", e_fetch(1'b1));
    step("halt_dec", e_dec(IMM_I));
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      step($sformatf("halt_hold%0d", i), E_HALT);
    end
    do_reset("halt_rst");

    run_illegal("ill_op7f", 32'h0000007F, IMM_I, 0);
    run_illegal("ill_br010", 32'h00002063, IMM_B, 1);
    run_illegal("ill_sll", 32'h00001433, IMM_I, 1);
    run_illegal("ill_mul", 32'h02000433, IMM_I, 1);
    run_illegal("ill_sub_f3", 32'h40007433, IMM_I, 1);

    for (int i = 0; i < 3; i++) run_alu($sformatf("cnt_add%0d", i), 32'h00000433, 3'd0);
    run_lw("cnt_lw", 0);
    step("cnt_back_fetch", e_fetch(1'b1));
`ifdef RETIRE_CNT_EN
    chk("retired_4", retired, 32'd4);
`endif

    set_ir(32'h00040483);
    step("abort_dec", e_dec(IMM_I));
    step("abort_madr", e_madr(IMM_I));
    mem_ready = 1'b0;
    step("abort_mread", E_MREAD);
    do_reset("abort_rst");
    for (int i = 0; i < 3; i++) step($sformatf("abort_idle%0d", i), e_fetch(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
